hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with the ports listed below (clock and reset first).
REQ-002 The block SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port RST, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port ihit, input, 1 bit: instruction fetch completes this cycle.
REQ-005 The block SHALL have port dhit, input, 1 bit: data access in MEM completes this cycle.
REQ-006 The block SHALL have port mem_access, input, 1 bit: EX/MEM holds a load or store.
REQ-007 The block SHALL have port idex_memread, input, 1 bit: ID/EX holds a load.
REQ-008 The block SHALL have port idex_rd, input, 5 bits: destination register of the ID/EX instruction.
REQ-009 The block SHALL have ports ifid_rs and ifid_rt, inputs, 5 bits each: source registers of the IF/ID instruction.
REQ-010 The block SHALL have port redirect, input, 1 bit: branch/jump resolved in EX with a wrong-path fetch.
REQ-011 The block SHALL have port halt_mem, input, 1 bit: halt instruction is in MEM.
REQ-012 The block SHALL have ports pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en and memwb_en, outputs, 1 bit each: enable/flush controls for the PC and the pipeline registers (flush overrides en at the register).
REQ-013 The block SHALL have port halted, output, 1 bit: the pipeline is halted.
REQ-014 The block SHALL have port stall_cycles, output, 16 bits: saturating count of stalled cycles.

Function
REQ-015 The block SHALL hold one state register with the states RUN, MEMW and HALT.
REQ-016 All enable/flush outputs SHALL be combinational functions of the state and the current inputs.
REQ-017 The hazard term lu SHALL equal idex_memread AND idex_rd!=0 AND (idex_rd==ifid_rs OR idex_rd==ifid_rt).
REQ-018 In RUN, exactly one rule SHALL apply per cycle, in priority order (a) through (f), given in REQ-019 to REQ-024.
REQ-019 (a) When halt_mem=1, the block SHALL drive memwb_en=1 and all other en/flush outputs 0, and move to HALT next cycle.
REQ-020 (b) When mem_access=1 and dhit=0, the block SHALL drive all en and flush outputs to 0 (full freeze) and move to MEMW next cycle.
REQ-021 (c) When redirect=1, the block SHALL drive pc_en=1, ifid_flush=1, idex_flush=1, exmem_en=1 and memwb_en=1, regardless of ihit and lu.
REQ-022 (d) When lu=1, the block SHALL drive pc_en=0, ifid_en=0, idex_flush=1, exmem_en=1 and memwb_en=1, regardless of ihit (one bubble per hazard cycle).
REQ-023 (e) When ihit=0, the block SHALL drive pc_en=0, ifid_flush=1, idex_en=1, exmem_en=1 and memwb_en=1.
REQ-024 (f) Otherwise, the block SHALL drive all en outputs to 1 and all flush outputs to 0.
REQ-025 In MEMW with dhit=0, the block SHALL keep the full freeze and stay in MEMW, with redirect, lu and ihit ignored.
REQ-026 In MEMW with dhit=1, the block SHALL evaluate rules (c) through (f) in the same cycle and move to RUN; halt_mem SHALL be ignored in MEMW.
REQ-027 In HALT, all en and flush outputs SHALL be 0 and halted SHALL be 1; HALT SHALL be left only by RST.
REQ-028 halted SHALL be 0 in RUN and MEMW.
REQ-029 stall_cycles SHALL increment by 1 on each edge where the state is RUN or MEMW, RST=0 and pc_en=0.
REQ-030 stall_cycles SHALL saturate at 0xFFFF with no wrap, and SHALL NOT count in HALT.
REQ-031 Rule (a) cycles SHALL NOT count toward stall_cycles.

Reset
REQ-032 When RST=1 at a rising edge, the block SHALL enter RUN with stall_cycles=0 on the next cycle, overriding any state including HALT or MEMW mid-wait.
REQ-033 While RST=1, the block SHALL drive pc_en, ifid_en, idex_en, exmem_en and memwb_en to 0, ifid_flush and idex_flush to 1, and halted to 0.
REQ-034 After RST deasserts, the first cycle SHALL be evaluated as RUN.

Verification
REQ-035 The bench SHALL check normal flow: RUN, ihit=1, no hazards -> all en=1, flushes=0, stall_cycles holds at 0.
REQ-036 The bench SHALL check load-use: idex_memread=1, idex_rd=5, ifid_rs=5 for 1 cycle -> pc_en=0, ifid_en=0, idex_flush=1, stall_cycles=1.
REQ-037 The bench SHALL check that a zero register causes no hazard: idex_rd=0, ifid_rt=0 -> no stall.
REQ-038 The bench SHALL check a data wait: mem_access=1, dhit=0 for 3 cycles, then dhit=1 -> freeze for 3 cycles (MEMW), all en=1 on the dhit cycle, state RUN after, stall_cycles=3.
REQ-039 The bench SHALL check simultaneous events: redirect=1, lu=1, ihit=0 in one cycle -> pc_en=1, ifid_flush=1, idex_flush=1, no stall counted.
REQ-040 The bench SHALL check halt: halt_mem=1 -> memwb_en=1 for that cycle; next cycle halted=1, all en=0; stays halted for 10 cycles; RST=1 -> RUN, halted=0, stall_cycles=0.
REQ-041 The bench SHALL check saturation and reset: hold ihit=0 for 70000 cycles -> stall_cycles=0xFFFF with no wrap; then RST during MEMW -> RUN next cycle.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and the hazard controller.
// The pipeline (master) reports hazard conditions; the controller (slave) returns stage enables/flushes.
interface hazard_ctrl_if;
   logic        ihit;
   logic        dhit;
   logic        mem_access;
   logic        idex_memread;
   logic [4:0]  idex_rd;
   logic [4:0]  ifid_rs;
   logic [4:0]  ifid_rt;
   logic        redirect;
   logic        halt_mem;
   logic        pc_en;
   logic        ifid_en;
   logic        ifid_flush;
   logic        idex_en;
   logic        idex_flush;
   logic        exmem_en;
   logic        memwb_en;
   logic        halted;
   logic [15:0] stall_cycles;

   modport master (
      output ihit, dhit, mem_access, idex_memread, idex_rd, ifid_rs, ifid_rt,
             redirect, halt_mem,
      input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en,
             halted, stall_cycles
   );

   modport slave (
      input  ihit, dhit, mem_access, idex_memread, idex_rd, ifid_rs, ifid_rt,
             redirect, halt_mem,
      output pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en,
             halted, stall_cycles
   );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: RUN / MEMW / HALT state machine producing stage enables and
// flushes combinationally, plus a saturating counter of cycles in which the PC was held.
module hazard_ctrl (
   input  logic         CLK,
   input  logic         RST,
   hazard_ctrl_if.slave hif
);

   typedef enum logic [1:0] {
      RUN  = 2'd0,
      MEMW = 2'd1,
      HALT = 2'd2
   } state_e;

   typedef struct packed {
      logic pc_en;
      logic ifid_en;
      logic ifid_flush;
      logic idex_en;
      logic idex_flush;
      logic exmem_en;
      logic memwb_en;
   } ctl_t;

   localparam ctl_t CTL_FREEZE = '0;
   localparam ctl_t CTL_RESET  = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b1, idex_en: 1'b0,
                                   idex_flush: 1'b1, exmem_en: 1'b0, memwb_en: 1'b0};
   localparam ctl_t CTL_HALTMEM = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b0, idex_en: 1'b0,
                                    idex_flush: 1'b0, exmem_en: 1'b0, memwb_en: 1'b1};

   // Rules shared by RUN and by the MEMW cycle in which the data access completes.
   function automatic ctl_t run_rules(input logic redirect, input logic lu, input logic ihit);
      ctl_t c;
      c = CTL_FREEZE;
      if (redirect) begin
         c.pc_en      = 1'b1;
         c.ifid_flush = 1'b1;
         c.idex_flush = 1'b1;
         c.exmem_en   = 1'b1;
         c.memwb_en   = 1'b1;
      end else if (lu) begin
         c.idex_flush = 1'b1;
         c.exmem_en   = 1'b1;
         c.memwb_en   = 1'b1;
      end else if (!ihit) begin
         c.ifid_flush = 1'b1;
         c.idex_en    = 1'b1;
         c.exmem_en   = 1'b1;
         c.memwb_en   = 1'b1;
      end else begin
         c.pc_en    = 1'b1;
         c.ifid_en  = 1'b1;
         c.idex_en  = 1'b1;
         c.exmem_en = 1'b1;
         c.memwb_en = 1'b1;
      end
      return c;
   endfunction

   state_e      state_q, state_d;
   logic [15:0] stall_q, stall_d;
   ctl_t        ctl;
   logic        halted;
   logic        lu;
   logic        rule_a;
   logic        count_en;

   assign lu = hif.idex_memread && (hif.idex_rd != 5'd0) &&
               ((hif.idex_rd == hif.ifid_rs) || (hif.idex_rd == hif.ifid_rt));

   always_comb begin
      state_d = state_q;
      ctl     = CTL_FREEZE;
      halted  = 1'b0;
      rule_a  = 1'b0;
      if (RST) begin
         ctl     = CTL_RESET;
         state_d = RUN;
      end else begin
         unique case (state_q)
            RUN: begin
               if (hif.halt_mem) begin
                  rule_a  = 1'b1;
                  ctl     = CTL_HALTMEM;
                  state_d = HALT;
               end else if (hif.mem_access && !hif.dhit) begin
                  state_d = MEMW;
               end else begin
                  ctl = run_rules(hif.redirect, lu, hif.ihit);
               end
            end
            MEMW: begin
               if (hif.dhit) begin
                  ctl     = run_rules(hif.redirect, lu, hif.ihit);
                  state_d = RUN;
               end
            end
            HALT: begin
               halted = 1'b1;
            end
            default: begin
               state_d = RUN;
            end
         endcase
      end
   end

   // Halt-entry cycles hold the PC but are not stalls.
   assign count_en = !RST && (state_q != HALT) && !ctl.pc_en && !rule_a;
   assign stall_d  = (count_en && (stall_q != 16'hFFFF)) ? stall_q + 16'd1 : stall_q;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= RUN;
         stall_q <= '0;
      end else begin
         state_q <= state_d;
         stall_q <= stall_d;
      end
   end

   assign hif.pc_en        = ctl.pc_en;
   assign hif.ifid_en      = ctl.ifid_en;
   assign hif.ifid_flush   = ctl.ifid_flush;
   assign hif.idex_en      = ctl.idex_en;
   assign hif.idex_flush   = ctl.idex_flush;
   assign hif.exmem_en     = ctl.exmem_en;
   assign hif.memwb_en     = ctl.memwb_en;
   assign hif.halted       = halted;
   assign hif.stall_cycles = stall_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized traffic,
// all compared against a rule-table reference model of the controller.
module tb_hazard_ctrl;

  logic CLK;
  logic RST;
  hazard_ctrl_if hif ();

  hazard_ctrl dut (
    .CLK (CLK),
    .RST (RST),
    .hif (hif)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_chk;
  int n_err;

  // Model state: 0 = RUN, 1 = MEMW, 2 = HALT
  int mst;
  int mcnt;

  // Expected {pc_en,ifid_en,ifid_flush,idex_en,idex_flush,exmem_en,memwb_en,halted} per rule
  localparam int R_RESET  = 0;
  localparam int R_HALTMEM = 1;
  localparam int R_FREEZE = 2;
  localparam int R_REDIR  = 3;
  localparam int R_LU     = 4;
  localparam int R_IMISS  = 5;
  localparam int R_NORMAL = 6;
  localparam int R_HALTED = 7;
  logic [7:0] exp_tab [8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] dut_vec();
    return {hif.pc_en, hif.ifid_en, hif.ifid_flush, hif.idex_en, hif.idex_flush,
            hif.exmem_en, hif.memwb_en, hif.halted};
  endfunction

  function automatic int rule_of(input logic rst_v, input logic ih, input logic dh,
                                 input logic ma, input logic mr, input logic [4:0] rd,
                                 input logic [4:0] rs, input logic [4:0] rt,
                                 input logic rdr, input logic hm);
    bit use_hz;
    use_hz = mr && (rd != 0) && (rd == rs || rd == rt);
    if (rst_v) return R_RESET;
    if (mst == 2) return R_HALTED;
    if (mst == 0 && hm) return R_HALTMEM;
    if (mst == 0 && ma && !dh) return R_FREEZE;
    if (mst == 1 && !dh) return R_FREEZE;
    if (rdr) return R_REDIR;
    if (use_hz) return R_LU;
    if (!ih) return R_IMISS;
    return R_NORMAL;
  endfunction

  // One cycle: apply inputs at the falling edge, check, then advance the model past the rising edge.
  task automatic step(input logic rst_v, input logic ih, input logic dh, input logic ma,
                      input logic mr, input logic [4:0] rd, input logic [4:0] rs,
                      input logic [4:0] rt, input logic rdr, input logic hm);
    int r;
    @(negedge CLK);
    RST = rst_v;
    hif.ihit = ih;  hif.dhit = dh;  hif.mem_access = ma;  hif.idex_memread = mr;
    hif.idex_rd = rd;  hif.ifid_rs = rs;  hif.ifid_rt = rt;
    hif.redirect = rdr;  hif.halt_mem = hm;
    #1;
    r = rule_of(rst_v, ih, dh, ma, mr, rd, rs, rt, rdr, hm);
    chk("ctl", {24'd0, dut_vec()}, {24'd0, exp_tab[r]});
    chk("stall", {16'd0, hif.stall_cycles}, mcnt);
    if (rst_v) begin
      mst = 0;
      mcnt = 0;
    end else begin
      if (mst != 2 && r != R_HALTMEM && exp_tab[r][7] == 1'b0 && mcnt < 65535) mcnt++;
      case (r)
        R_HALTMEM: mst = 2;
        R_FREEZE:  mst = 1;
        R_HALTED:  mst = 2;
        default:   mst = 0;
      endcase
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    exp_tab[R_RESET]   = 8'b0010_1000;
    exp_tab[R_HALTMEM] = 8'b0000_0010;
    exp_tab[R_FREEZE]  = 8'b0000_0000;
    exp_tab[R_REDIR]   = 8'b1010_1110;
    exp_tab[R_LU]      = 8'b0000_1110;
    exp_tab[R_IMISS]   = 8'b0011_0110;
    exp_tab[R_NORMAL]  = 8'b1101_0110;
    exp_tab[R_HALTED]  = 8'b0000_0001;

    RST = 1'b1;
    hif.ihit = 1'b0;  hif.dhit = 1'b0;  hif.mem_access = 1'b0;  hif.idex_memread = 1'b0;
    hif.idex_rd = '0;  hif.ifid_rs = '0;  hif.ifid_rt = '0;
    hif.redirect = 1'b0;  hif.halt_mem = 1'b0;
    repeat (2) @(posedge CLK);
    mst = 0;
    mcnt = 0;

    // Reset state
    do_reset();
    chk("rst_halted", {31'd0, hif.halted}, 0);
    chk("rst_ifid_flush", {31'd0, hif.ifid_flush}, 1);

    // Normal flow
    repeat (4) idle();
    chk("norm_pc_en", {31'd0, hif.pc_en}, 1);
    chk("norm_stall", {16'd0, hif.stall_cycles}, 0);

    // Load-use hazard for one cycle
    do_reset();
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 5'd9, 1'b0, 1'b0);
    chk("lu_pc_en", {31'd0, hif.pc_en}, 0);
    chk("lu_idex_flush", {31'd0, hif.idex_flush}, 1);
    idle();
    chk("lu_stall", {16'd0, hif.stall_cycles}, 1);

    // Register zero never creates a hazard
    do_reset();
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 5'd3, 5'd0, 1'b0, 1'b0);
    chk("r0_pc_en", {31'd0, hif.pc_en}, 1);
    idle();
    chk("r0_stall", {16'd0, hif.stall_cycles}, 0);

    // Data wait: three miss cycles then the hit
    do_reset();
    repeat (3) step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    chk("dw_hit_pc_en", {31'd0, hif.pc_en}, 1);
    chk("dw_hit_memwb", {31'd0, hif.memwb_en}, 1);
    idle();
    chk("dw_run_pc_en", {31'd0, hif.pc_en}, 1);
    chk("dw_stall", {16'd0, hif.stall_cycles}, 3);

    // Redirect wins over load-use and fetch miss
    do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 5'd7, 5'd1, 1'b1, 1'b0);
    chk("sim_pc_en", {31'd0, hif.pc_en}, 1);
    chk("sim_flushes", {30'd0, hif.ifid_flush, hif.idex_flush}, 3);
    idle();
    chk("sim_stall", {16'd0, hif.stall_cycles}, 0);

    // Halt: entered, held, left only by reset
    do_reset();
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    chk("halt_memwb", {31'd0, hif.memwb_en}, 1);
    for (int i = 0; i < 10; i++)
      step(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom));
    chk("halt_held", {31'd0, hif.halted}, 1);
    chk("halt_stall", {16'd0, hif.stall_cycles}, 0);
    do_reset();
    idle();
    chk("halt_exit", {31'd0, hif.halted}, 0);
    chk("halt_exit_stall", {16'd0, hif.stall_cycles}, 0);

    // Saturation, then reset in the middle of a data wait
    do_reset();
    repeat (70000) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    idle();
    chk("sat_stall", {16'd0, hif.stall_cycles}, 32'h0000_FFFF);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    chk("memw_rst_run", {31'd0, hif.pc_en}, 1);
    chk("memw_rst_stall", {16'd0, hif.stall_cycles}, 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++)
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) < 3),
           1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)), ($urandom_range(0, 5) == 0), ($urandom_range(0, 39) == 0));

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
